// File: rtl/ufifo_txuart_if.sv
// FIFO read-port, flow-control and serial-line signals of the UART transmitter.
// The transmitter takes the master side; the FIFO and line environment take the slave side.
interface ufifo_txuart_if;
  logic       i_fifo_empty_n;
  logic [7:0] i_fifo_data;
  logic       o_fifo_rd;
  logic       i_cts_n;
  logic       i_break;
  logic       o_uart_tx;
  logic       o_busy;

  modport master (
    input  i_fifo_empty_n,
    input  i_fifo_data,
    input  i_cts_n,
    input  i_break,
    output o_fifo_rd,
    output o_uart_tx,
    output o_busy
  );

  modport slave (
    output i_fifo_empty_n,
    output i_fifo_data,
    output i_cts_n,
    output i_break,
    input  o_fifo_rd,
    input  o_uart_tx,
    input  o_busy
  );
endinterface

// File: rtl/ufifo_txuart.sv
// Pops bytes from the transmit FIFO and serialises them as 8N1 UART frames, LSB first,
// with CTS gating at frame start and continuous line-break generation.
module ufifo_txuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868,
  parameter int          LGCPB           = 24
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  ufifo_txuart_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam logic [LGCPB-1:0] BAUD_LOAD = LGCPB'(CLOCKS_PER_BAUD - 24'd1);

  state_t           state_q, state_d;
  logic [LGCPB-1:0] baud_q, baud_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic             tx_q, tx_d;

  logic baud_zero;
  logic pop_slot;
  logic fifo_rd;

  assign baud_zero = (baud_q == '0);

  // A new frame may only be launched from idle or in the final cycle of a stop bit,
  // which is what lets frames chain with no gap.
  assign pop_slot = (state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_zero);
  assign fifo_rd  = i_rst_n && bus.i_fifo_empty_n && !bus.i_cts_n && !bus.i_break && pop_slot;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    shift_d = shift_q;
    bit_d   = bit_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_break) begin
          state_d = ST_BREAK;
          baud_d  = BAUD_LOAD;
        end else if (fifo_rd) begin
          state_d = ST_START;
          baud_d  = BAUD_LOAD;
          shift_d = bus.i_fifo_data;
        end
      end

      ST_START: begin
        if (baud_zero) begin
          state_d = ST_DATA;
          baud_d  = BAUD_LOAD;
          bit_d   = 3'd0;
        end else begin
          baud_d  = baud_q - 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_zero) begin
          baud_d  = BAUD_LOAD;
          shift_d = {1'b1, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d  = baud_q - 1'b1;
        end
      end

      ST_STOP: begin
        if (baud_zero) begin
          if (bus.i_break) begin
            state_d = ST_BREAK;
            baud_d  = BAUD_LOAD;
          end else if (fifo_rd) begin
            state_d = ST_START;
            baud_d  = BAUD_LOAD;
            shift_d = bus.i_fifo_data;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d  = baud_q - 1'b1;
        end
      end

      ST_BREAK: begin
        // Leaving break always costs one full stop bit so the receiver sees a clean idle.
        baud_d = BAUD_LOAD;
        if (!bus.i_break) begin
          state_d = ST_STOP;
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // The line level is registered from the next state so the pin is glitch-free.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_IDLE:  tx_d = 1'b1;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      ST_STOP:  tx_d = 1'b1;
      ST_BREAK: tx_d = 1'b0;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      shift_q <= 8'hff;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.o_fifo_rd = fifo_rd;
  assign bus.o_uart_tx = tx_q;
  assign bus.o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ufifo_txuart.sv
// Directed bench for ufifo_txuart at four clocks per baud, with a small FIFO model
// feeding the read port and frame waveforms compared against hand-built bit vectors.
module tb_ufifo_txuart;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ufifo_txuart_if ifc ();

  ufifo_txuart #(
    .CLOCKS_PER_BAUD (24'd4),
    .LGCPB           (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int pops   = 0;
  logic [7:0] pend[$];
  logic [7:0] fq[$];

  // FIFO model: pop on o_fifo_rd, flags and head byte registered (one-cycle lag)
  always @(posedge clk) begin
    if (ifc.o_fifo_rd) begin
      pops <= pops + 1;
      if (fq.size() > 0) void'(fq.pop_front());
    end
    while (pend.size() > 0) fq.push_back(pend.pop_front());
    ifc.i_fifo_empty_n <= (fq.size() != 0);
    ifc.i_fifo_data    <= (fq.size() != 0) ? fq[0] : 8'h00;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] b);
    pend.push_back(b);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rd(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ifc.o_fifo_rd) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check({tag, "_rd_timeout"}, 0, 1);
  endtask

  // Expected line per cycle: lead idle-high cycles, up to two frames, trailing high cycles
  function automatic logic [127:0] frame_vec(input logic [7:0] b0, input logic [7:0] b1,
                                             input int nfr, input int lead, input int trail);
    logic [127:0] v;
    logic [7:0]   bb;
    logic         sym;
    int           k;
    v = '0;
    k = 0;
    for (int i = 0; i < lead; i++) begin
      v[k] = 1'b1;
      k++;
    end
    for (int f = 0; f < nfr; f++) begin
      bb = (f == 0) ? b0 : b1;
      for (int s = 0; s < 10; s++) begin
        if (s == 0)      sym = 1'b0;
        else if (s == 9) sym = 1'b1;
        else             sym = bb[s-1];
        for (int c = 0; c < CPB; c++) begin
          v[k] = sym;
          k++;
        end
      end
    end
    for (int i = 0; i < trail; i++) begin
      v[k] = 1'b1;
      k++;
    end
    return v;
  endfunction

  task automatic capture(input int n, input int cts_at, output logic [127:0] txv,
                         output int npop, output int pk0);
    txv  = '0;
    npop = 0;
    pk0  = -1;
    for (int k = 0; k < n; k++) begin
      step();
      txv[k] = ifc.o_uart_tx;
      if (ifc.o_fifo_rd) begin
        if (npop == 0) pk0 = k;
        npop++;
      end
      if (k == cts_at) ifc.i_cts_n = 1'b1;
    end
  endtask

  initial begin
    logic [127:0] txv;
    int npop, pk0, p0, nrd, nlow, nhigh;

    ifc.i_cts_n = 1'b0;
    ifc.i_break = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx", ifc.o_uart_tx, 1);
    check("rst_busy", ifc.o_busy, 0);
    check("rst_rd", ifc.o_fifo_rd, 0);
    rst_n = 1'b1;

    // empty FIFO
    nrd = 0; nlow = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ifc.o_fifo_rd) nrd++;
      if (!ifc.o_uart_tx) nlow++;
    end
    check("empty_rd", nrd, 0);
    check("empty_low", nlow, 0);

    // single byte
    push(8'h35);
    wait_rd("b35");
    p0 = pops;
    capture(40, -1, txv, npop, pk0);
    check("b35_frame", txv, frame_vec(8'h35, 8'h00, 1, 0, 0));
    check("b35_extra_pop", npop, 0);
    check("b35_busy_last", ifc.o_busy, 1);
    step();
    check("b35_busy_end", ifc.o_busy, 0);
    check("b35_idle_tx", ifc.o_uart_tx, 1);
    check("b35_pops", pops - p0, 1);

    // back-to-back
    push(8'hA5);
    push(8'h00);
    wait_rd("b2b");
    p0 = pops;
    capture(80, -1, txv, npop, pk0);
    check("b2b_frames", txv, frame_vec(8'hA5, 8'h00, 2, 0, 0));
    check("b2b_npop", npop, 1);
    check("b2b_pop_at", pk0, 39);
    step();
    check("b2b_busy_end", ifc.o_busy, 0);
    check("b2b_pops", pops - p0, 2);

    // CTS blocks, then releases; raising it mid-frame does not abort
    ifc.i_cts_n = 1'b1;
    push(8'h5A);
    nrd = 0; nlow = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (ifc.o_fifo_rd) nrd++;
      if (!ifc.o_uart_tx) nlow++;
    end
    check("cts_block_rd", nrd, 0);
    check("cts_block_low", nlow, 0);
    ifc.i_cts_n = 1'b0;
    #1;
    check("cts_release_rd", ifc.o_fifo_rd, 1);
    capture(40, 15, txv, npop, pk0);
    check("cts_frame", txv, frame_vec(8'h5A, 8'h00, 1, 0, 0));
    check("cts_extra_pop", npop, 0);
    step();
    check("cts_busy_end", ifc.o_busy, 0);
    ifc.i_cts_n = 1'b0;

    // break from idle, bytes queued during break, release
    ifc.i_break = 1'b1;
    step();
    check("brk_line0", ifc.o_uart_tx, 0);
    push(8'hC3);
    nrd = 0; nhigh = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (ifc.o_fifo_rd) nrd++;
      if (ifc.o_uart_tx) nhigh++;
    end
    check("brk_rd", nrd, 0);
    check("brk_high", nhigh, 0);
    check("brk_busy", ifc.o_busy, 1);
    ifc.i_break = 1'b0;
    capture(44, -1, txv, npop, pk0);
    check("brk_release", txv, frame_vec(8'hC3, 8'h00, 1, 4, 0));
    check("brk_npop", npop, 1);
    check("brk_pop_at", pk0, 3);
    step();
    check("brk_busy_end", ifc.o_busy, 0);

    // reset during data bit 3
    push(8'hF0);
    wait_rd("rstf");
    capture(18, -1, txv, npop, pk0);
    check("rst_pre_bit3", txv[17], 0);
    push(8'h81);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", ifc.o_uart_tx, 1);
    check("rst_mid_busy", ifc.o_busy, 0);
    check("rst_mid_rd", ifc.o_fifo_rd, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_after_rd", ifc.o_fifo_rd, 1);
    capture(40, -1, txv, npop, pk0);
    check("rst_after_frame", txv, frame_vec(8'h81, 8'h00, 1, 0, 0));
    step();
    check("rst_after_busy", ifc.o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
